// File: rtl/uart_mmio_ctrl_pkg.sv
// Shared constants and types for the memory-mapped UART controller.
// Default register addresses, STATUS bit positions and the TX FSM encoding.
package uart_mmio_ctrl_pkg;

    localparam logic [31:0] UartDataAddr = 32'hBFD0_03F8;
    localparam logic [31:0] UartStatAddr = 32'hBFD0_03FC;

    localparam int unsigned StatTxReadyBit = 0;
    localparam int unsigned StatRxAvailBit = 1;
    localparam int unsigned StatOverrunBit = 2;

    typedef enum logic [1:0] {
        TxIdle     = 2'd0,
        TxStart    = 2'd1,
        TxWaitBusy = 2'd2,
        TxWaitDone = 2'd3
    } tx_state_e;

    // Pack the three status flags into the STATUS register word.
    function automatic logic [31:0] status_word(input logic overrun, input logic rx_avail,
                                                input logic tx_ready);
        logic [31:0] w;
        w                 = '0;
        w[StatOverrunBit] = overrun;
        w[StatRxAvailBit] = rx_avail;
        w[StatTxReadyBit] = tx_ready;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO with combinational head. A push to a full FIFO is accepted
// only when a pop happens in the same cycle (the slot frees up at that edge).
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [7:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            wr_en;
    logic            rd_en;

    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        if (wr_en && !rd_en) count_d = count_q + 1'b1;
        if (rd_en && !wr_en) count_d = count_q - 1'b1;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: DATA/STATUS register decode, TX handshake FSM
// towards async_transmitter and an RX FIFO fed by async_receiver.
// Build option: define UART_MMIO_INT_EN to get a registered interrupt request
// (rx_avail | overrun); otherwise int_o is tied low.
module uart_mmio_ctrl
    import uart_mmio_ctrl_pkg::*;
#(
    parameter int unsigned RX_DEPTH  = 16,
    parameter logic [31:0] DATA_ADDR = UartDataAddr,
    parameter logic [31:0] STAT_ADDR = UartStatAddr
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        hit_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_start_o,
    input  logic        tx_busy_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_ready_i,
    output logic        rx_clear_o,
    output logic        int_o
);

    tx_state_e tx_state_q, tx_state_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       overrun_q, overrun_d;

    logic       data_sel, stat_sel;
    logic       rd_data, rd_stat, wr_data;
    logic       tx_ready, rx_avail, rx_pop;
    logic [7:0] rx_head;
    logic [$clog2(RX_DEPTH):0] rx_count;
    logic       rx_full, rx_empty;

    // Only the low byte of a DATA write is meaningful.
    logic       unused_bits;
    assign unused_bits = ^{sel_i[3:1], data_i[31:8]};

    assign data_sel = ce_i & (addr_i == DATA_ADDR);
    assign stat_sel = ce_i & (addr_i == STAT_ADDR);
    assign hit_o    = data_sel | stat_sel;

    assign rd_data  = data_sel & ~we_i;
    assign rd_stat  = stat_sel & ~we_i;
    assign wr_data  = data_sel & we_i & sel_i[0];

    assign tx_ready = (tx_state_q == TxIdle) & ~tx_busy_i;
    assign rx_avail = (rx_count != '0);
    assign rx_pop   = rd_data & ~rx_empty;

    assign tx_start_o = (tx_state_q == TxStart);
    assign tx_data_o  = tx_data_q;
    assign rx_clear_o = rx_ready_i;

    uart_rx_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_ready_i),
        .din   (rx_data_i),
        .pop   (rx_pop),
        .dout  (rx_head),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // Read mux; an empty DATA read returns zero.
    always_comb begin
        data_o = '0;
        if (rd_stat) begin
            data_o = status_word(overrun_q, rx_avail, tx_ready);
        end else if (rd_data && !rx_empty) begin
            data_o = {24'b0, rx_head};
        end
    end

    // Overrun: cleared by a STATUS read, set by a push the FIFO cannot absorb.
    always_comb begin
        overrun_d = overrun_q;
        if (rd_stat) overrun_d = 1'b0;
        if (rx_ready_i && rx_full && !rx_pop) overrun_d = 1'b1;
    end

    // TX handshake: pulse start, then follow the transmitter's busy cycle.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_data_d  = tx_data_q;
        unique case (tx_state_q)
            TxIdle: begin
                if (wr_data && tx_ready) begin
                    tx_state_d = TxStart;
                    tx_data_d  = data_i[7:0];
                end
            end
            TxStart:    tx_state_d = TxWaitBusy;
            TxWaitBusy: if (tx_busy_i) tx_state_d = TxWaitDone;
            TxWaitDone: if (!tx_busy_i) tx_state_d = TxIdle;
            default:    tx_state_d = TxIdle;
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TxIdle;
            tx_data_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_data_q  <= tx_data_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef UART_MMIO_INT_EN
    logic int_q;

    // Interrupt request, one cycle behind the status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) int_q <= 1'b0;
        else     int_q <= rx_avail | overrun_q;
    end

    assign int_o = int_q;
`else
    assign int_o = 1'b0;
`endif

endmodule
